// File: rtl/rptr_empty.sv
// Read-side pointer, empty / almost-empty flags and fill level for a dual-clock FIFO.
// Optional sticky underflow flag enabled by defining RPTR_UNDERFLOW_EN.
module rptr_empty #(
  parameter int ASIZE     = 4,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rinc,
  input  logic [ASIZE:0]   WSR2_ptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rempty,
  output logic             raempty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam logic [ASIZE:0] AE_LIM = (ASIZE+1)'(AE_THRESH);

  logic [ASIZE:0] rbin_q, rbin_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] rlevel_q, rlevel_d;
  logic           rempty_q, rempty_d;
  logic           raempty_q, raempty_d;
  logic [ASIZE:0] wbin_s;
  logic           pop;

  always_comb begin
    pop    = rinc & ~rempty_q;
    rbin_d = rbin_q + (ASIZE+1)'(pop);
    rptr_d = (rbin_d >> 1) ^ rbin_d;

    // Gray-to-binary: each bit is the XOR of itself and every higher Gray bit.
    wbin_s = WSR2_ptr;
    for (int unsigned i = 1; i <= ASIZE; i++) begin
      wbin_s = wbin_s ^ (WSR2_ptr >> i);
    end

    // Flags come from next-state pointers so the last pop raises empty on its own edge.
    rempty_d  = (rptr_d == WSR2_ptr);
    rlevel_d  = wbin_s - rbin_d;
    raempty_d = (rlevel_d <= AE_LIM);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic runderflow_q, runderflow_d;

  always_comb begin
    runderflow_d = runderflow_q | (rinc & rempty_q);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      runderflow_q <= 1'b0;
    end else begin
      runderflow_q <= runderflow_d;
    end
  end

  assign runderflow = runderflow_q;
`else
  assign runderflow = 1'b0;
`endif

  assign rptr    = rptr_q;
  assign raddr   = rbin_q[ASIZE-1:0];
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Scoreboard bench for rptr_empty (ASIZE=4, AE_THRESH=2); stimulus pushes expectations,
// a monitor pops and compares after each rclk edge or asynchronous-reset event.
module tb_rptr_empty;

`ifdef RPTR_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic       rclk;
  logic       rrst;
  logic       rinc;
  logic [4:0] WSR2_ptr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;
  logic       runderflow;

  rptr_empty #(.ASIZE(4), .AE_THRESH(2)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .rinc       (rinc),
    .WSR2_ptr   (WSR2_ptr),
    .rptr       (rptr),
    .raddr      (raddr),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel),
    .runderflow (runderflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    string      nm;
    logic [4:0] ptr;
    logic [3:0] addr;
    logic       emp;
    logic       ae;
    logic [4:0] lvl;
    logic       uf;
    bit         chk_ptr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  event async_ev;
  bit   last_emp = 1'b1;
  bit   uf_exp   = 1'b0;

  task automatic cmp(input string nm, input string f, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%b required=%b", nm, f, act, exp);
    end
  endtask

  // Monitor: one expectation consumed per edge (or async event) when available.
  initial begin
    exp_t e;
    forever begin
      @(posedge rclk or async_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_ptr) cmp(e.nm, "rptr", rptr, e.ptr);
        cmp(e.nm, "raddr",      {1'b0, raddr},      {1'b0, e.addr});
        cmp(e.nm, "rempty",     {4'b0, rempty},     {4'b0, e.emp});
        cmp(e.nm, "raempty",    {4'b0, raempty},    {4'b0, e.ae});
        cmp(e.nm, "rlevel",     rlevel,             e.lvl);
        cmp(e.nm, "runderflow", {4'b0, runderflow}, {4'b0, e.uf});
      end
    end
  end

  task automatic push(input string nm, input logic [4:0] ptr, input logic [3:0] addr,
                      input bit emp, input bit ae, input logic [4:0] lvl, input bit chkp);
    exp_t e;
    e.nm = nm; e.ptr = ptr; e.addr = addr; e.emp = emp; e.ae = ae;
    e.lvl = lvl; e.uf = uf_exp; e.chk_ptr = chkp;
    q.push_back(e);
  endtask

  task automatic step(input bit inc, input logic [4:0] w, input string nm,
                      input logic [4:0] ptr, input logic [3:0] addr,
                      input bit emp, input bit ae, input logic [4:0] lvl, input bit chkp);
    @(negedge rclk);
    rinc     = inc;
    WSR2_ptr = w;
    if (!rrst && inc && last_emp && UF_EN) uf_exp = 1'b1;
    push(nm, ptr, addr, emp, ae, lvl, chkp);
    last_emp = emp;
  endtask

  task automatic async_reset(input string nm);
    @(negedge rclk);
    #2;
    rrst = 1'b1;
    #1;
    uf_exp   = 1'b0;
    last_emp = 1'b1;
    push(nm, 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    -> async_ev;
    #2;
  endtask

  task automatic release_rst();
    @(negedge rclk);
    rrst     = 1'b0;
    rinc     = 1'b0;
    WSR2_ptr = 5'b00000;
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rrst     = 1'b1;
    rinc     = 1'b0;
    WSR2_ptr = 5'($urandom);
    #2;
    push("reset_async", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    -> async_ev;
    #2;
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'($urandom), "reset_hold", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    release_rst();
    step(1'b0, 5'b00000, "idle", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b1);

    // Single word
    step(1'b0, 5'b00001, "one_word",  5'b00000, 4'd0, 1'b0, 1'b1, 5'd1, 1'b1);
    step(1'b1, 5'b00001, "one_pop",   5'b00001, 4'd1, 1'b1, 1'b1, 5'd0, 1'b1);
    step(1'b1, 5'b00001, "underflow", 5'b00001, 4'd1, 1'b1, 1'b1, 5'd0, 1'b1);
    step(1'b0, 5'b00001, "uf_sticky", 5'b00001, 4'd1, 1'b1, 1'b1, 5'd0, 1'b1);

    async_reset("uf_clear");
    step(1'b0, 5'b00000, "rst_hold2", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    release_rst();

    // Full drain: gray(16)=11000
    step(1'b0, 5'b11000, "full", 5'b00000, 4'd0, 1'b0, 1'b0, 5'd16, 1'b1);
    for (int k = 0; k < 16; k++)
      step(1'b1, 5'b11000, "drain", 5'b11000, 4'(k + 1), (k == 15), ((15 - k) <= 2),
           5'(15 - k), (k == 15));
    step(1'b1, 5'b11000, "drain_extra", 5'b11000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b1);

    // Advance rbin 16 -> 31 against gray(31)=10000, then wrap
    step(1'b0, 5'b10000, "fill15", 5'b11000, 4'd0, 1'b0, 1'b0, 5'd15, 1'b1);
    for (int k = 0; k < 15; k++)
      step(1'b1, 5'b10000, "to31", 5'b10000, 4'(k + 1), (k == 14), ((14 - k) <= 2),
           5'(14 - k), (k == 14));
    step(1'b0, 5'b00000, "wrap_lvl", 5'b10000, 4'd15, 1'b0, 1'b1, 5'd1, 1'b1);
    step(1'b1, 5'b00000, "wrap_pop", 5'b00000, 4'd0,  1'b1, 1'b1, 5'd0, 1'b1);

    // Almost-empty boundary: gray(3)=00010, gray(4)=00110
    step(1'b0, 5'b00010, "ae_lvl3",   5'b00000, 4'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    step(1'b1, 5'b00010, "ae_lvl2",   5'b00001, 4'd1, 1'b0, 1'b1, 5'd2, 1'b1);
    step(1'b1, 5'b00110, "same_edge", 5'b00011, 4'd2, 1'b0, 1'b1, 5'd2, 1'b1);
    async_reset("mid_rst");
    step(1'b1, 5'b00110, "rst_hold3", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    release_rst();
    step(1'b0, 5'b00110, "post_rst",  5'b00000, 4'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    step(1'b1, 5'b00110, "post_pop",  5'b00001, 4'd1, 1'b0, 1'b0, 5'd3, 1'b1);

    @(negedge rclk);
    rinc = 1'b0;
    @(negedge rclk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
Read-side pointer and empty-flag logic of the dual-clock FIFO; the counterpart of the write-pointer/full block on the write clock domain. Holds the binary read pointer (RAM read address) and the Gray read pointer exported to the write domain. It compares against the write Gray pointer already synchronised into the read domain to produce registered empty, almost-empty and fill-level outputs.

Parameters:
ASIZE, 4, address width; FIFO depth = 2^ASIZE entries, pointers are ASIZE+1 bits.
AE_THRESH, 2, almost-empty threshold in entries (0..2^ASIZE).

Ports:
rclk  input  1  read-domain clock; all state updates on rising edge.
rrst  input  1  asynchronous active-high reset.
rinc  input  1  read request; pops one word when rempty=0.
WSR2_ptr  input  ASIZE+1  write Gray pointer after 2-flop sync into rclk domain.
rptr  output  ASIZE+1  registered Gray read pointer, to write-domain synchroniser.
raddr  output  ASIZE  RAM read address = rbin[ASIZE-1:0].
rempty  output  1  registered empty flag.
raempty  output  1  registered almost-empty flag.
rlevel  output  ASIZE+1  registered fill level as seen by read domain, 0..2^ASIZE.
runderflow  output  1  sticky underflow error (see Optional Feature).

Behaviour:
- One clock (rclk); reset asynchronous, active-high (rrst). Reset is fixed; do not change polarity or synchronicity.
- Reset values: rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0. Assertion takes effect immediately, not at the next edge, including mid-transfer. First update occurs on the first rclk edge after deassertion.
- Pop qualifier: pop = rinc & ~rempty. rinc while rempty=1 is ignored; pointers hold.
- rbinnext = rbin + pop. The increment is zero-extended to ASIZE+1 bits for any ASIZE, with modulo 2^(ASIZE+1) wrap: 2^(ASIZE+1)-1 -> 0.
- rgraynext = (rbinnext >> 1) ^ rbinnext. {rbin, rptr} <= {rbinnext, rgraynext} each edge.
- Exactly one rptr bit changes per pop; no change when pop=0.
- Empty: rempty <= (rgraynext == WSR2_ptr). Computed from next-state pointer so the flag is valid the same cycle rptr updates; the last pop sets rempty on that edge with zero bubble.
- Level: wbin_s = Gray-to-binary of WSR2_ptr (bit i = XOR of bits ASIZE..i). rlevel <= wbin_s - rbinnext, modulo 2^(ASIZE+1).
- Almost-empty: raempty <= (level_next <= AE_THRESH), where level_next is the value loaded into rlevel.
- WSR2_ptr changing on the same edge as a pop: both are used together in the next-state compare. There is no ordering priority.
- All flags are pessimistic. rempty may stay 1 up to 2 cycles after a write because of synchroniser latency. It never deasserts early.
- WSR2_ptr is trusted. The block does not check level > 2^ASIZE.

Optional Feature:
Macro RPTR_UNDERFLOW_EN.
- Defined: runderflow is a flop, set on any rclk edge with rinc=1 and rempty=1. It is sticky and cleared only by rrst.
- Undefined: runderflow is tied to constant 0 and no flop is inferred. The port exists in both builds.

Test Plan:
- Reset: rrst=1 with random WSR2_ptr -> rptr=00000, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0. Release rrst; WSR2_ptr=00000 -> all outputs hold.
- Single word: WSR2_ptr=00001 -> next edge rempty=0, rlevel=1, raempty=1. One-cycle rinc -> rptr=00001, raddr=1, rempty=1, rlevel=0.
- Full drain: WSR2_ptr=11000 (gray 16), rinc held 17 cycles -> raddr steps 0..15, rlevel 16 down to 0. rempty=1 after the 16th pop, rptr=11000; the 17th rinc is ignored.
- Wrap: preload via 31 pops (rbin=31, rptr=10000) then WSR2_ptr=00000 -> rlevel=1, rempty=0. rinc -> rbin=0, rptr=00000, raddr=0, rempty=1.
- Almost-empty (AE_THRESH=2): level 3 gives raempty=0. One pop -> rlevel=2, raempty=1. Mid-stream async rrst pulse -> outputs reset before the next edge.
- Underflow: rinc=1 while rempty=1 -> pointers unchanged. runderflow=1 and stays 1 until rrst with RPTR_UNDERFLOW_EN; runderflow=0 without it.
